// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B4 classic slave in front of an asynchronous 32-bit
// SRAM with active-low ce/oe/we/be and split data in/out plus a tristate control.
// One transaction at a time. Reads ack three cycles after the request is
// sampled, writes ack four cycles after. Every output is registered.
// Optional feature: define WB_SRAM_ERR_EN to answer requests that fall outside
// the BASE_ADDR window with a one-cycle err. The SRAM is not touched in that
// case. Without the macro the window aliases and wb_err_o stays 0.
module wb_sram_slave #(
    parameter int unsigned SRAM_ADDR_WIDTH = 20,
    parameter logic [31:0] BASE_ADDR       = 32'h8000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_cyc_i,
    input  logic                       wb_stb_i,
    input  logic                       wb_we_i,
    input  logic [31:0]                wb_adr_i,
    input  logic [31:0]                wb_dat_i,
    input  logic [3:0]                 wb_sel_i,
    output logic [31:0]                wb_dat_o,
    output logic                       wb_ack_o,
    output logic                       wb_err_o,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]                sram_data_o,
    input  logic [31:0]                sram_data_i,
    output logic                       sram_data_t,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic [3:0]                 sram_be_n
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        READ_2,
        WRITE,
        WRITE_2,
        WRITE_3,
        DONE
    } state_t;

    state_t state;
    logic   request;
    logic   addr_err;

    assign request = wb_cyc_i & wb_stb_i;

`ifdef WB_SRAM_ERR_EN
    // Requests outside the SRAM window are answered with err and never reach the SRAM.
    assign addr_err = (wb_adr_i[31:SRAM_ADDR_WIDTH+2] != BASE_ADDR[31:SRAM_ADDR_WIDTH+2]);

    // The two byte-offset bits have no meaning for a word-wide SRAM.
    logic unused_adr;
    assign unused_adr = &{1'b0, wb_adr_i[1:0]};
`else
    // Without window checking the upper address bits alias onto the SRAM.
    assign addr_err = 1'b0;

    // The upper bits, the byte offset and the base address play no part in this build.
    logic unused_adr;
    assign unused_adr = &{1'b0, wb_adr_i[31:SRAM_ADDR_WIDTH+2], wb_adr_i[1:0], BASE_ADDR};
`endif

    // Access sequencer: drives the SRAM strobes one state at a time and answers the bus from DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= 32'h0;
            sram_addr   <= '0;
            sram_data_o <= 32'h0;
            sram_data_t <= 1'b1;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_be_n   <= 4'hF;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (request) begin
                        if (addr_err) begin
                            wb_err_o <= 1'b1;
                            state    <= DONE;
                        end else begin
                            sram_addr <= wb_adr_i[SRAM_ADDR_WIDTH+1:2];
                            sram_be_n <= ~wb_sel_i;
                            sram_ce_n <= 1'b0;
                            sram_we_n <= 1'b1;
                            if (wb_we_i) begin
                                sram_data_o <= wb_dat_i;
                                sram_data_t <= 1'b0;
                                state       <= WRITE;
                            end else begin
                                sram_oe_n   <= 1'b0;
                                sram_data_t <= 1'b1;
                                state       <= READ;
                            end
                        end
                    end
                end
                READ: begin
                    state <= READ_2;
                end
                READ_2: begin
                    wb_dat_o  <= sram_data_i;
                    sram_ce_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    sram_be_n <= 4'hF;
                    wb_ack_o  <= wb_cyc_i;
                    state     <= DONE;
                end
                WRITE: begin
                    sram_we_n <= 1'b0;
                    state     <= WRITE_2;
                end
                WRITE_2: begin
                    sram_we_n <= 1'b1;
                    state     <= WRITE_3;
                end
                WRITE_3: begin
                    sram_ce_n   <= 1'b1;
                    sram_be_n   <= 4'hF;
                    sram_data_t <= 1'b1;
                    wb_ack_o    <= wb_cyc_i;
                    state       <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: drives wb_sram_slave with directed and random Wishbone
// traffic. An SRAM model reacts to the DUT strobes. Every response is checked
// against a word-array reference of the expected memory contents.
module tb_wb_sram_slave;

    localparam int unsigned AW        = 10;
    localparam logic [31:0] BASE      = 32'h8000_0000;
    localparam logic [31:0] LOW_MASK  = (32'd1 << (AW + 2)) - 32'd1;
    localparam logic [31:0] WORD_MASK = (32'd1 << AW) - 32'd1;
`ifdef WB_SRAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wb_cyc_i;
    logic          wb_stb_i;
    logic          wb_we_i;
    logic [31:0]   wb_adr_i;
    logic [31:0]   wb_dat_i;
    logic [3:0]    wb_sel_i;
    logic [31:0]   wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_data_o;
    logic [31:0]   sram_data_i;
    logic          sram_data_t;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [3:0]    sram_be_n;

    // Words as the SRAM holds them (written only by DUT strobes).
    logic [31:0] sram    [0:(1<<AW)-1];
    // Words as they should be after every completed transaction.
    logic [31:0] ref_mem [0:(1<<AW)-1];

    int   total = 0;
    int   bad   = 0;
    int   we_low_total = 0;
    int   access_total = 0;
    int   viol_total   = 0;
    logic [3:0]  last_be_n = 4'hF;
    logic [31:0] last_read = 32'h0;
    bit   loaded  = 1'b0;
    logic ce_prev = 1'b1;
    logic [31:0] rd_word;

    wb_sram_slave #(.SRAM_ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .sram_addr(sram_addr), .sram_data_o(sram_data_o), .sram_data_i(sram_data_i),
        .sram_data_t(sram_data_t), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous SRAM read port: only enabled byte lanes are driven, others read as 0.
    always_comb begin
        rd_word     = sram[sram_addr];
        sram_data_i = 32'h0;
        if (!sram_ce_n && !sram_oe_n) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) sram_data_i[8*b +: 8] = rd_word[8*b +: 8];
            end
        end
    end

    // SRAM write side and strobe watcher, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            if (!loaded) begin
                for (int i = 0; i < (1 << AW); i++) sram[i] = ref_mem[i];
                loaded = 1'b1;
            end
        end else begin
            if (!sram_ce_n && ce_prev) access_total++;
            if (!sram_ce_n) last_be_n = sram_be_n;
            if (!sram_we_n) we_low_total++;
            if (!sram_we_n && !sram_oe_n) viol_total++;
            if (!sram_data_t && (sram_ce_n || !sram_oe_n)) viol_total++;
            if (!sram_ce_n && !sram_we_n && !sram_data_t) begin
                for (int b = 0; b < 4; b++) begin
                    if (!sram_be_n[b]) sram[sram_addr][8*b +: 8] = sram_data_o[8*b +: 8];
                end
            end
        end
        ce_prev = sram_ce_n;
    end

    function automatic logic [31:0] lanes(input logic [3:0] sel);
        logic [31:0] m;
        m = 32'h0;
        for (int b = 0; b < 4; b++) if (sel[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] dat,
                                          input logic [3:0] sel);
        return (old & ~lanes(sel)) | (dat & lanes(sel));
    endfunction

    // One Wishbone transfer; reports the cycle ack/err arrived (-1 if never) and ack/err one cycle later.
    task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input int drop_at, input bit hold_stb,
                            output int ack_cyc, output int err_cyc, output logic [31:0] rdata,
                            output logic extra);
        ack_cyc = -1;
        err_cyc = -1;
        rdata   = 32'h0;
        extra   = 1'b0;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = adr;  wb_dat_i = dat;  wb_sel_i = sel;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == drop_at) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
            if (wb_ack_o) begin
                ack_cyc = n;
                rdata   = wb_dat_o;
            end
            if (wb_err_o) err_cyc = n;
            if (ack_cyc >= 0 || err_cyc >= 0) break;
            if (drop_at > 0 && n >= drop_at + 3) break;
        end
        if (!hold_stb) begin
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        end
        @(posedge clk); #1;
        extra = wb_ack_o | wb_err_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        total++;
        if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_data_t} !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL reset_strobes: got %b want 11111111",
                     {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_data_t});
        end
        total++;
        if ({wb_ack_o, wb_err_o} !== 2'b00 || wb_dat_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_bus: got ack=%b err=%b dat=%h want 0 0 0", wb_ack_o, wb_err_o, wb_dat_o);
        end
        total++;
        if (sram_addr !== '0 || sram_data_o !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_sram_bus: got addr=%h data=%h want 0 0", sram_addr, sram_data_o);
        end
    endtask

    task automatic test_read_basic();
        int ack_c, err_c, we0, acc0;
        logic [31:0] rd;
        logic extra;
        we0 = we_low_total; acc0 = access_total;
        bus_xfer(1'b0, 32'h8000_0010, $urandom, 4'hF, 0, 1'b0, ack_c, err_c, rd, extra);
        total++;
        if (ack_c !== 3 || err_c !== -1) begin
            bad++; $display("[TB] FAIL read_latency: got ack=%0d err=%0d want ack=3 err=-1", ack_c, err_c);
        end
        total++;
        if (rd !== 32'hDEADBEEF) begin
            bad++; $display("[TB] FAIL read_data: got %h want deadbeef", rd);
        end
        total++;
        if (we_low_total - we0 !== 0 || access_total - acc0 !== 1) begin
            bad++; $display("[TB] FAIL read_strobes: got we_low=%0d accesses=%0d want 0 1",
                            we_low_total - we0, access_total - acc0);
        end
        total++;
        if (extra !== 1'b0) begin
            bad++; $display("[TB] FAIL read_ack_pulse: got %b want 0", extra);
        end
        last_read = 32'hDEADBEEF;
    endtask

    task automatic test_write_basic();
        int ack_c, err_c, we0;
        logic [31:0] rd;
        logic extra;
        we0 = we_low_total;
        ref_mem[1] = merge(ref_mem[1], 32'h0000AB00, 4'b0010);
        bus_xfer(1'b1, 32'h8000_0005, 32'h0000AB00, 4'b0010, 0, 1'b0, ack_c, err_c, rd, extra);
        total++;
        if (ack_c !== 4) begin
            bad++; $display("[TB] FAIL write_latency: got ack=%0d want 4", ack_c);
        end
        total++;
        if (last_be_n !== 4'b1101) begin
            bad++; $display("[TB] FAIL write_be_n: got %b want 1101", last_be_n);
        end
        total++;
        if (we_low_total - we0 !== 1) begin
            bad++; $display("[TB] FAIL write_we_width: got %0d want 1", we_low_total - we0);
        end
        total++;
        if (sram[1] !== ref_mem[1]) begin
            bad++; $display("[TB] FAIL write_byte1: got %h want %h", sram[1], ref_mem[1]);
        end
        total++;
        if (wb_dat_o !== last_read) begin
            bad++; $display("[TB] FAIL write_keeps_dat_o: got %h want %h", wb_dat_o, last_read);
        end
    endtask

    task automatic test_back_to_back();
        int ack_c, err_c, acc0;
        logic [31:0] rd;
        logic extra;
        for (int k = 0; k < 2; k++) begin
            acc0 = access_total;
            if (k == 0) begin
                bus_xfer(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 1'b1, ack_c, err_c, rd, extra);
            end else begin
                ref_mem[7] = merge(ref_mem[7], 32'h1234_5678, 4'hF);
                bus_xfer(1'b1, 32'h8000_001C, 32'h1234_5678, 4'hF, 0, 1'b1, ack_c, err_c, rd, extra);
            end
            total++;
            if (access_total - acc0 !== 1 || extra !== 1'b0 || ack_c !== 3 + k) begin
                bad++;
                $display("[TB] FAIL hold_stb[%0d]: got accesses=%0d ack_after=%b ack=%0d want 1 0 %0d",
                         k, access_total - acc0, extra, ack_c, 3 + k);
            end
        end
        total++;
        if (sram[7] !== 32'h1234_5678) begin
            bad++; $display("[TB] FAIL hold_stb_write: got %h want 12345678", sram[7]);
        end
    endtask

    task automatic test_cyc_drop();
        int ack_c, err_c, we0;
        logic [31:0] rd;
        logic extra;
        we0 = we_low_total;
        ref_mem[9] = merge(ref_mem[9], 32'hCAFE_F00D, 4'b1001);
        bus_xfer(1'b1, 32'h8000_0024, 32'hCAFE_F00D, 4'b1001, 2, 1'b0, ack_c, err_c, rd, extra);
        total++;
        if (ack_c !== -1 || extra !== 1'b0) begin
            bad++; $display("[TB] FAIL drop_no_ack: got ack=%0d after=%b want -1 0", ack_c, extra);
        end
        total++;
        if (sram[9] !== ref_mem[9] || we_low_total - we0 !== 1) begin
            bad++; $display("[TB] FAIL drop_write_lands: got %h we_low=%0d want %h 1",
                            sram[9], we_low_total - we0, ref_mem[9]);
        end
        bus_xfer(1'b0, 32'h8000_0024, 32'h0, 4'hF, 0, 1'b0, ack_c, err_c, rd, extra);
        total++;
        if (ack_c !== 3 || rd !== ref_mem[9]) begin
            bad++; $display("[TB] FAIL drop_then_read: got ack=%0d data=%h want 3 %h", ack_c, rd, ref_mem[9]);
        end
        last_read = ref_mem[9];
    endtask

    task automatic test_reset_mid_write();
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
        wb_adr_i = 32'h8000_0030; wb_dat_i = 32'h5555_AAAA; wb_sel_i = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (sram_we_n !== 1'b0) begin
            bad++; $display("[TB] FAIL rst_pre_we_low: got %b want 0", sram_we_n);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({sram_we_n, sram_ce_n, sram_data_t, wb_ack_o} !== 4'b1110) begin
            bad++; $display("[TB] FAIL rst_mid_write: got we_n,ce_n,t,ack=%b want 1110",
                            {sram_we_n, sram_ce_n, sram_data_t, wb_ack_o});
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_read = 32'h0;
        @(posedge clk); #1;
    endtask

    task automatic test_window();
        int ack_c, err_c, acc0;
        logic [31:0] rd;
        logic extra;
        acc0 = access_total;
        bus_xfer(1'b0, 32'h9000_0000, 32'h0, 4'hF, 0, 1'b0, ack_c, err_c, rd, extra);
        if (ERR_EN) begin
            total++;
            if (err_c !== 1 || ack_c !== -1 || access_total - acc0 !== 0) begin
                bad++; $display("[TB] FAIL window_err: got err=%0d ack=%0d accesses=%0d want 1 -1 0",
                                err_c, ack_c, access_total - acc0);
            end
        end else begin
            total++;
            if (ack_c !== 3 || err_c !== -1 || rd !== ref_mem[0]) begin
                bad++; $display("[TB] FAIL window_alias: got ack=%0d err=%0d data=%h want 3 -1 %h",
                                ack_c, err_c, rd, ref_mem[0]);
            end
            last_read = ref_mem[0];
        end
    endtask

    task automatic test_random();
        logic [31:0] adr, dat, rd, upper, exp_rd;
        logic [3:0]  sel;
        logic        we, extra;
        int          ack_c, err_c, w, we0, acc0;
        bit          exp_err;
        for (int i = 0; i < 40; i++) begin
            we    = 1'($urandom_range(0, 1));
            dat   = $urandom;
            sel   = 4'($urandom_range(0, 15));
            upper = ($urandom_range(0, 3) == 0) ? $urandom : BASE;
            adr   = (upper & ~LOW_MASK) | ($urandom & LOW_MASK);
            w     = int'((adr >> 2) & WORD_MASK);
            exp_err = ERR_EN && ((adr >> (AW + 2)) != (BASE >> (AW + 2)));
            we0 = we_low_total; acc0 = access_total;
            bus_xfer(we, adr, dat, sel, 0, bit'($urandom_range(0, 1)), ack_c, err_c, rd, extra);
            total++;
            if (exp_err) begin
                if (err_c !== 1 || ack_c !== -1 || access_total - acc0 !== 0 || wb_dat_o !== last_read) begin
                    bad++; $display("[TB] FAIL rand_err[%0d]: got err=%0d ack=%0d acc=%0d dat=%h want 1 -1 0 %h",
                                    i, err_c, ack_c, access_total - acc0, wb_dat_o, last_read);
                end
            end else if (we) begin
                ref_mem[w] = merge(ref_mem[w], dat, sel);
                if (ack_c !== 4 || sram[w] !== ref_mem[w] || we_low_total - we0 !== 1 ||
                    access_total - acc0 !== 1 || wb_dat_o !== last_read) begin
                    bad++; $display("[TB] FAIL rand_write[%0d]: got ack=%0d word=%h we_low=%0d acc=%0d dat_o=%h want 4 %h 1 1 %h",
                                    i, ack_c, sram[w], we_low_total - we0, access_total - acc0, wb_dat_o,
                                    ref_mem[w], last_read);
                end
            end else begin
                exp_rd = ref_mem[w] & lanes(sel);
                if (ack_c !== 3 || rd !== exp_rd || we_low_total - we0 !== 0 || access_total - acc0 !== 1) begin
                    bad++; $display("[TB] FAIL rand_read[%0d]: got ack=%0d data=%h we_low=%0d acc=%0d want 3 %h 0 1",
                                    i, ack_c, rd, we_low_total - we0, access_total - acc0, exp_rd);
                end
                last_read = exp_rd;
            end
            total++;
            if (extra !== 1'b0) begin
                bad++; $display("[TB] FAIL rand_pulse[%0d]: got %b want 0", i, extra);
            end
        end
    endtask

    task automatic test_strobe_rules();
        total++;
        if (viol_total !== 0) begin
            bad++; $display("[TB] FAIL strobe_overlap: got %0d want 0", viol_total);
        end
    endtask

    // Global time limit so a stuck run still ends with a report.
    initial begin
        #500000;
        $display("[TB] FAIL timeout: got no finish want finish");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        rst = 1'b1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        wb_adr_i = 32'h0; wb_dat_i = 32'h0; wb_sel_i = 4'h0;
        for (int i = 0; i < (1 << AW); i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_read_basic();
        test_write_basic();
        test_back_to_back();
        test_cyc_drop();
        test_reset_mid_write();
        test_window();
        test_random();
        test_strobe_rules();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
